instr_loader: RTL
=================

# instr_loader

Byte-serial instruction loader that fills the core's instruction memory before execution. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake and assembles 32-bit RV32 words. It writes them to consecutive instruction-memory addresses and holds the core in reset while loading. It is the producer side of the instruction stream that the control unit decodes; optionally it screens each word against the opcode set the control unit supports.

## Interface
- ADDR_W, 12: instruction-memory word-address width; capacity 2^ADDR_W words.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts byte this cycle.
- imem_we  out  1  instruction-memory write strobe (one cycle per word).
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  holds core in reset while a load is active.
- word_count  out  ADDR_W+1  words written in current/last load.
- done  out  1  level; load completed.
- illegal  out  1  sticky; an unsupported instruction was loaded (see Configuration).

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE.
- IDLE/DONE: start=1 -> LEN_LO; clear word_count, byte index, illegal, done.
- LEN_LO: accepted byte -> length[7:0]; -> LEN_HI.
- LEN_HI: accepted byte -> length[15:8]; length==0 -> DONE, else -> DATA.
- Length is clamped to 2^ADDR_W words; excess words beyond capacity are not loaded (stream is not consumed past the clamp).
- DATA: accepted bytes fill word little-endian: byte k -> bits [8k+7:8k], k=0..3; after k=3 -> WRITE.
- WRITE: imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata=assembled word; word_count increments; -> DONE if word_count+1==length, else DATA.
- byte_ready=1 only in LEN_LO, LEN_HI, DATA. Byte accepted iff byte_valid && byte_ready.
- cpu_hold=1 in LEN_LO, LEN_HI, DATA, WRITE; 0 in IDLE, DONE.
- done=1 only in DONE; start in DONE begins a new load.
- start outside IDLE/DONE is ignored.

## Timing
- Reset: state IDLE; byte_ready, imem_we, cpu_hold, done, illegal = 0; imem_addr, imem_wdata, word_count = 0.
- rst mid-load: next cycle IDLE with all reset values; no further writes; memory retains words already written.
- cpu_hold rises the cycle after start is sampled; falls the cycle DONE is entered.
- Per word: 4 accepted bytes + 1 WRITE cycle; minimum 5 cycles/word with byte_valid held high. byte_ready is 0 in WRITE (one bubble per word).
- Minimum load of N words: 2 + 5N cycles from LEN_LO entry to DONE entry.
- imem_we, imem_addr, imem_wdata are registered, valid in the WRITE-state cycle only; imem_we=0 elsewhere.
- byte_valid low stalls indefinitely with no state change; no timeout.
- word_count and illegal hold in DONE until next start.

## Configuration
- INSTR_CHECK_EN defined: in WRITE, word is legal iff opcode[6:0] is 0110011 (R), 0010011 (I-ALU), 0110111 (LUI), or 1110011 with funct3==001 (CSRRW). Illegal word: illegal set (sticky) in the WRITE cycle, word still written.
- Not defined: illegal tied to 0; no check logic.

## Test plan
- Reset then idle: all outputs 0, byte_ready=0 with byte_valid=1 -> no state change.
- start, bytes 01 00 33 05 B5 00 -> one write at addr 0, data 0x00B50533, done=1, word_count=1, cpu_hold high from LEN_LO through WRITE.
- start, length 00 00 -> DONE after 2 bytes, no imem_we, word_count=0.
- Three words with byte_valid toggling every other cycle -> addrs 0,1,2 written in order, data intact, byte_ready=0 in each WRITE.
- rst asserted after 2nd data byte of word 1 -> IDLE next cycle, cpu_hold=0, only word 0 written; new start reloads from addr 0.
- INSTR_CHECK_EN: words 0x00000013 then 0x0000006F -> illegal=0 after first, 1 after second, both written; next start clears illegal.

Source files
------------

// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory write bundle for instr_loader.
// The slave modport is the loader; the master modport is the stream source / memory side.
interface instr_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Length-prefixed little-endian byte loader that fills instruction memory while holding the core.
// Define INSTR_CHECK_EN to flag words whose opcode the control unit does not support.
module instr_loader #(
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    instr_loader_if.slave      bus,
    output logic               cpu_hold,
    output logic [ADDR_W:0]    word_count,
    output logic               done,
    output logic               illegal
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;

    logic              accept;
    logic              load_word;
    logic              start_load;
    logic [31:0]       wr_word;
    logic [31:0]       len_full;
    logic [31:0]       len_clamp;
    logic [ADDR_W:0]   count_inc;

    assign accept     = bus.byte_valid && bus.byte_ready;
    assign load_word  = (state_q == DATA) && accept && (idx_q == 2'd3);
    assign start_load = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign wr_word    = {bus.byte_in, word_q};
    assign len_full   = {16'd0, bus.byte_in, len_lo_q};
    // Words beyond capacity are never requested, so the stream stops at the clamp.
    assign len_clamp  = (len_full > CAPACITY) ? CAPACITY : len_full;
    assign count_inc  = count_q + 1'b1;

    // The first three bytes of a word are parked in lanes; the fourth goes straight to the write.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign word_d[8*gi +: 8] = ((state_q == DATA) && accept && (idx_q == 2'(gi)))
                                       ? bus.byte_in : word_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        idx_d        = idx_q;
        count_d      = count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LEN_LO;
                    count_d = '0;
                    idx_d   = 2'd0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_lo_d = bus.byte_in;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d   = len_clamp[ADDR_W:0];
                    state_d = (len_clamp == 32'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = count_q[ADDR_W-1:0];
                        imem_wdata_d = wr_word;
                        state_d      = WRITE;
                    end
                end
            end
            WRITE: begin
                count_d = count_inc;
                state_d = (count_inc == len_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            count_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            count_q      <= count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

`ifdef INSTR_CHECK_EN
    logic illegal_q, illegal_d;
    logic word_legal;

    always_comb begin
        unique case (wr_word[6:0])
            7'b0110011, 7'b0010011, 7'b0110111: word_legal = 1'b1;
            7'b1110011:                         word_legal = (wr_word[14:12] == 3'b001);
            default:                            word_legal = 1'b0;
        endcase
    end

    // Evaluated as the word is captured so the flag is already up during its WRITE cycle.
    always_comb begin
        illegal_d = illegal_q;
        if (start_load) begin
            illegal_d = 1'b0;
        end else if (load_word && !word_legal) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    logic unused_check;
    assign unused_check = load_word ^ start_load;
    assign illegal      = 1'b0;
`endif

    assign bus.byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign cpu_hold       = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                            (state_q == DATA)   || (state_q == WRITE);
    assign done           = (state_q == DONE);
    assign word_count     = count_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;

endmodule
